// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between two producers:
//   port P - pipeline writeback. It has priority and is never buffered.
//   port L - long-latency producers (mul/div, memory returns). These are
//            queued in a small in-order FIFO. A starvation counter forces
//            the FIFO head through after STARVE_LIMIT consecutive P grants.
// The register-file write inputs are driven from registers. pending_mask
// flags every destination that is queued or being written this cycle.
// Register 0 is never written.
//
// Handshake: a port transfers on the rising clock edge where its valid and
// ready are both high. valid must not depend on ready. ready depends only
// on internal state. l_ready is simply !full, so a full FIFO refuses a push
// even if it pops on the same edge.
//
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   p_valid/p_address/p_data        pipeline write request
//   p_ready                         P request accepted this cycle
//   l_valid/l_address/l_data        long-latency write request
//   l_ready                         L FIFO can accept
//   write_address/write_data_in     registered register-file write inputs
//   WriteEnable                     registered register-file write strobe
//   pending_mask                    bit i = write to register i in flight
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_address,
  input  logic [31:0] p_data,
  output logic        p_ready,
  input  logic        l_valid,
  input  logic [4:0]  l_address,
  input  logic [31:0] l_data,
  output logic        l_ready,
  output logic [4:0]  write_address,
  output logic [31:0] write_data_in,
  output logic        WriteEnable,
  output logic [31:0] pending_mask
);

  localparam int AW = $clog2(DEPTH);

  // FIFO storage and bookkeeping.
  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    starve_cnt;

  logic empty;
  logic full;
  logic force_l;
  logic grant_p;
  logic grant_l;
  logic push;
  logic pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // The head is forced through once P has won STARVE_LIMIT times in a row
  // while something was waiting.
  assign force_l = !empty && (starve_cnt == 4'(STARVE_LIMIT));
  assign grant_p = p_valid && !force_l;
  assign grant_l = !empty && !grant_p;

  // p_ready stays high when P is idle; accepting nothing is harmless.
  assign p_ready = !force_l;
  assign l_ready = !full;

  assign push = l_valid && !full;
  assign pop  = grant_l;

  // Storage needs no reset: only entries counted by count are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= l_address;
      fifo_data[wr_ptr] <= l_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counts P wins while the FIFO holds something. It is judged on the
  // current occupancy, so a push landing alongside a P grant does not count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (empty || grant_l) begin
      starve_cnt <= '0;
    end else if (grant_p && (starve_cnt != 4'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register-file write port. Address and data hold when nothing is granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_address <= '0;
      write_data_in <= '0;
      WriteEnable   <= 1'b0;
    end else if (grant_p) begin
      write_address <= p_address;
      write_data_in <= p_data;
      WriteEnable   <= (p_address != 5'd0);
    end else if (grant_l) begin
      write_address <= fifo_addr[rd_ptr];
      write_data_in <= fifo_data[rd_ptr];
      WriteEnable   <= (fifo_addr[rd_ptr] != 5'd0);
    end else begin
      WriteEnable   <= 1'b0;
    end
  end

  // Pending mask from state only: every occupied FIFO slot plus the write
  // being presented this cycle. Duplicates keep their bit set until the
  // last matching entry has left.
  logic [AW-1:0] slot;

  always_comb begin
    pending_mask = '0;
    slot         = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + AW'(k);
      if (k < int'(count)) begin
        pending_mask[fifo_addr[slot]] = 1'b1;
      end
    end
    if (WriteEnable) begin
      pending_mask[write_address] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p_valid = 1'b0;
  logic [4:0]  p_address = '0;
  logic [31:0] p_data = '0;
  logic        p_ready;
  logic        l_valid = 1'b0;
  logic [4:0]  l_address = '0;
  logic [31:0] l_data = '0;
  logic        l_ready;
  logic [4:0]  write_address;
  logic [31:0] write_data_in;
  logic        WriteEnable;
  logic [31:0] pending_mask;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .p_valid       (p_valid),
    .p_address     (p_address),
    .p_data        (p_data),
    .p_ready       (p_ready),
    .l_valid       (l_valid),
    .l_address     (l_address),
    .l_data        (l_data),
    .l_ready       (l_ready),
    .write_address (write_address),
    .write_data_in (write_data_in),
    .WriteEnable   (WriteEnable),
    .pending_mask  (pending_mask)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are then observed 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    p_valid = 1'b0;
    l_valid = 1'b0;
  endtask

  // Directed tables for the back-to-back L push run (bit c = after edge c).
  logic [15:0] lr_tab     = 16'b1111_1100_0010_0001;
  logic [15:0] pr_tab     = 16'b1011_1101_1110_1111;
  logic [15:0] commit_tab = 16'b1000_0100_0010_0000;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  li;
    logic lr;

    // ---- reset state ----
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_we",      WriteEnable,   1'b0);
    check("rst_waddr",   write_address, 5'd0);
    check("rst_wdata",   write_data_in, 32'd0);
    check("rst_mask",    pending_mask,  32'd0);
    check("rst_p_ready", p_ready,       1'b1);
    check("rst_l_ready", l_ready,       1'b1);

    // ---- single P write ----
    p_valid = 1'b1; p_address = 5'd5; p_data = 32'hDEADBEEF;
    check("t1_p_ready", p_ready, 1'b1);
    tick();
    p_valid = 1'b0;
    check("t1_we",    WriteEnable,   1'b1);
    check("t1_waddr", write_address, 5'd5);
    check("t1_wdata", write_data_in, 32'hDEADBEEF);
    check("t1_mask",  pending_mask,  32'h20);
    tick();
    check("t1_we_off",   WriteEnable,   1'b0);
    check("t1_mask_off", pending_mask,  32'h0);
    check("t1_hold",     write_address, 5'd5);

    // ---- P write to register 0 ----
    p_valid = 1'b1; p_address = 5'd0; p_data = 32'h1234;
    check("t2_p_ready", p_ready, 1'b1);
    tick();
    p_valid = 1'b0;
    check("t2_we",    WriteEnable,   1'b0);
    check("t2_mask",  pending_mask,  32'h0);
    check("t2_wdata", write_data_in, 32'h1234);

    // ---- starvation: one L entry, P saturated ----
    l_valid = 1'b1; l_address = 5'd7; l_data = 32'hA;
    tick();
    l_valid = 1'b0;
    check("t3_we_push",   WriteEnable,  1'b0);
    check("t3_mask_push", pending_mask, 32'h80);
    for (int i = 1; i <= 4; i++) begin
      p_valid = 1'b1; p_address = 5'(i); p_data = 32'h100 + 32'(i);
      tick();
      check("t3_p_waddr", write_address, 5'(i));
      check("t3_p_wdata", write_data_in, 32'h100 + 32'(i));
      check("t3_p_mask",  pending_mask,  32'h80 | (32'h1 << i));
      check("t3_p_ready", p_ready,       (i < 4) ? 1'b1 : 1'b0);
    end
    p_address = 5'd5; p_data = 32'h105;
    tick();
    check("t3_l_we",    WriteEnable,   1'b1);
    check("t3_l_waddr", write_address, 5'd7);
    check("t3_l_wdata", write_data_in, 32'hA);
    check("t3_l_mask",  pending_mask,  32'h80);
    check("t3_resume",  p_ready,       1'b1);
    tick();
    check("t3_p5_waddr", write_address, 5'd5);
    check("t3_p5_wdata", write_data_in, 32'h105);
    check("t3_p5_mask",  pending_mask,  32'h20);
    idle_inputs();
    tick();
    check("t3_idle_mask", pending_mask, 32'h0);

    // ---- three back-to-back L pushes into a 2-deep FIFO, P saturated ----
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(10 + i), 32'hB1 + 32'(i)});
    li = 0;
    for (int c = 0; c < 16; c++) begin
      l_valid   = (li < 3);
      l_address = 5'(10 + li);
      l_data    = 32'hB1 + 32'(li);
      p_valid   = 1'b1;
      p_address = 5'd20;
      p_data    = 32'h200 + 32'(c);
      lr = l_ready;
      tick();
      if (l_valid && lr) li++;
      check("t4_we",      WriteEnable, 1'b1);
      check("t4_l_ready", l_ready,     lr_tab[c]);
      check("t4_p_ready", p_ready,     pr_tab[c]);
      if (commit_tab[c]) begin
        check("t4_sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("t4_l_commit", {write_address, write_data_in}, exp_q.pop_front());
      end else begin
        check("t4_p_waddr", write_address, 5'd20);
        check("t4_p_wdata", write_data_in, 32'h200 + 32'(c));
      end
    end
    check("t4_l_accepted", li, 3);
    check("t4_sb_left",    exp_q.size(), 0);
    idle_inputs();
    tick();
    check("t4_idle_mask", pending_mask, 32'h0);

    // ---- duplicate L addresses, P idle ----
    l_valid = 1'b1; l_address = 5'd9; l_data = 32'h1;
    tick();
    check("t5_we0",   WriteEnable,  1'b0);
    check("t5_mask0", pending_mask, 32'h200);
    l_data = 32'h2;
    tick();
    l_valid = 1'b0;
    check("t5_wdata1", write_data_in, 32'h1);
    check("t5_waddr1", write_address, 5'd9);
    check("t5_mask1",  pending_mask,  32'h200);
    tick();
    check("t5_wdata2", write_data_in, 32'h2);
    check("t5_we2",    WriteEnable,   1'b1);
    check("t5_mask2",  pending_mask,  32'h200);
    tick();
    check("t5_we3",   WriteEnable,  1'b0);
    check("t5_mask3", pending_mask, 32'h0);

    // ---- reset with two L entries queued and a write in flight ----
    p_valid = 1'b1; p_address = 5'd4; p_data = 32'h44;
    l_valid = 1'b1; l_address = 5'd3; l_data = 32'h33;
    tick();
    l_address = 5'd6; l_data = 32'h66;
    tick();
    check("t6_pre_we",      WriteEnable,  1'b1);
    check("t6_pre_mask",    pending_mask, 32'h58);
    check("t6_pre_l_ready", l_ready,      1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_we",      WriteEnable,   1'b0);
    check("t6_rst_waddr",   write_address, 5'd0);
    check("t6_rst_wdata",   write_data_in, 32'd0);
    check("t6_rst_mask",    pending_mask,  32'd0);
    check("t6_rst_p_ready", p_ready,       1'b1);
    check("t6_rst_l_ready", l_ready,       1'b1);
    idle_inputs();
    @(posedge clock);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_post_we",      WriteEnable,  1'b0);
      check("t6_post_mask",    pending_mask, 32'h0);
      check("t6_post_l_ready", l_ready,      1'b1);
    end

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
